ysyx_22051110_cache_miss_ctrl: RTL and testbench

YSYX_22051110_CACHE_MISS_CTRL -- requirements
Module: ysyx_22051110_cache_miss_ctrl

---
 rtl/ysyx_22051110_cache_miss_ctrl.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_ysyx_22051110_cache_miss_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22051110_cache_miss_ctrl.sv
// ============================================================================
// ysyx_22051110_cache_miss_ctrl
//
// Purpose:
//   Controller for a direct-mapped, write-back, write-allocate cache whose
//   line is a single 64-bit word. It looks up the meta/data RAMs, answers hits
//   in one cycle, and on a miss optionally writes back a dirty victim before
//   refilling the line from memory. Also supports invalidate-all (flush).
//
// Ports:
//   clock, reset                        sole clock; async active-low reset
//   req_*                               CPU request channel (valid/ready)
//   resp_valid, resp_rdata              CPU response, 1-cycle pulse
//   flush_in                            invalidate-all, honoured in IDLE
//   meta_en/wr/flush/addr/w*            meta RAM command port
//   meta_valid/dirty/tag                meta RAM read data (1-cycle latency)
//   data_en/wr/addr/wdata/wmask         data RAM command port
//   data_rdata                          data RAM read data (1-cycle latency)
//   mem_req_*/mem_wr/mem_addr/mem_wdata memory request (valid/ready)
//   mem_resp_valid, mem_rdata           memory response
//
// Address split: tag = addr[31:9], index = addr[8:3], addr[2:0] byte offset.
// ============================================================================
module ysyx_22051110_cache_miss_ctrl #(
    parameter int TAG_W = 23,
    parameter int IDX_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    // CPU request / response
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic             req_wr,
    input  logic [63:0]      req_wdata,
    input  logic [7:0]       req_wmask,
    output logic             resp_valid,
    output logic [63:0]      resp_rdata,
    input  logic             flush_in,
    // meta RAM
    output logic             meta_en,
    output logic             meta_wr,
    output logic             meta_flush,
    output logic [IDX_W-1:0] meta_addr,
    output logic             meta_wvalid,
    output logic             meta_wdirty,
    output logic [TAG_W-1:0] meta_wtag,
    input  logic             meta_valid,
    input  logic             meta_dirty,
    input  logic [TAG_W-1:0] meta_tag,
    // data RAM
    output logic             data_en,
    output logic             data_wr,
    output logic [IDX_W-1:0] data_addr,
    output logic [63:0]      data_wdata,
    output logic [7:0]       data_wmask,
    input  logic [63:0]      data_rdata,
    // memory bus
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [63:0]      mem_wdata,
    input  logic             mem_resp_valid,
    input  logic [63:0]      mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB_REQ,
        S_WB_WAIT,
        S_RF_REQ,
        S_RF_WAIT,
        S_REFILL,
        S_FLUSH
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched request and miss-handling context
    logic [TAG_W-1:0] r_tag;
    logic [IDX_W-1:0] r_idx;
    logic             r_wr;
    logic [63:0]      r_wdata;
    logic [7:0]       r_wmask;
    logic [TAG_W-1:0] r_vic_tag;
    logic [63:0]      r_vic_data;
    logic [63:0]      r_refill;

    logic             w_accept;
    logic             w_vic_latch;
    logic             w_refill_latch;
    logic             w_hit;
    logic [63:0]      w_merge;

    // The byte offset never reaches the cache: one line is one word.
    logic             w_unused_offset;
    assign w_unused_offset = &{1'b0, req_addr[2:0]};

    assign w_hit = meta_valid && (meta_tag == r_tag);

    // Store miss: bytes selected by the store mask overwrite the refill word.
    always_comb begin
        w_merge = r_refill;
        for (int i = 0; i < 8; i++) begin
            if (r_wmask[i]) begin
                w_merge[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Request / victim / refill latches
    // ------------------------------------------------------------------------
    // NOTE: these are a handful of context flops, not a RAM array, so they get
    // a real reset; a reset abort then leaves no stale context behind.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag      <= '0;
            r_idx      <= '0;
            r_wr       <= 1'b0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_vic_tag  <= '0;
            r_vic_data <= '0;
            r_refill   <= '0;
        end else begin
            if (w_accept) begin
                r_tag   <= req_addr[31 -: TAG_W];
                r_idx   <= req_addr[3 +: IDX_W];
                r_wr    <= req_wr;
                r_wdata <= req_wdata;
                r_wmask <= req_wmask;
            end
            if (w_vic_latch) begin
                r_vic_tag  <= meta_tag;
                r_vic_data <= data_rdata;
            end
            if (w_refill_latch) begin
                r_refill <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    // NOTE: every output gets a default before the case statement; a path
    // that skipped an assignment would otherwise infer a latch.
    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        w_vic_latch    = 1'b0;
        w_refill_latch = 1'b0;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        meta_en        = 1'b0;
        meta_wr        = 1'b0;
        meta_flush     = 1'b0;
        meta_addr      = '0;
        meta_wvalid    = 1'b0;
        meta_wdirty    = 1'b0;
        meta_wtag      = '0;
        data_en        = 1'b0;
        data_wr        = 1'b0;
        data_addr      = '0;
        data_wdata     = '0;
        data_wmask     = '0;
        mem_req_valid  = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;

        if (!reset) begin
            // Outputs are quiet during reset regardless of live inputs.
            req_ready = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (flush_in) begin
                        meta_flush = 1'b1;
                        w_next     = S_FLUSH;
                    end else begin
                        req_ready = 1'b1;
                        if (req_valid) begin
                            w_accept  = 1'b1;
                            meta_en   = 1'b1;
                            data_en   = 1'b1;
                            meta_addr = req_addr[3 +: IDX_W];
                            data_addr = req_addr[3 +: IDX_W];
                            w_next    = S_LOOKUP;
                        end
                    end
                end

                S_LOOKUP: begin
                    if (w_hit) begin
                        resp_valid = 1'b1;
                        if (r_wr) begin
                            data_en     = 1'b1;
                            data_wr     = 1'b1;
                            data_addr   = r_idx;
                            data_wdata  = r_wdata;
                            data_wmask  = r_wmask;
                            meta_en     = 1'b1;
                            meta_wr     = 1'b1;
                            meta_addr   = r_idx;
                            meta_wvalid = 1'b1;
                            meta_wdirty = 1'b1;
                            meta_wtag   = r_tag;
                        end else begin
                            resp_rdata = data_rdata;
                        end
                        w_next = S_IDLE;
                    end else if (meta_valid && meta_dirty) begin
                        w_vic_latch = 1'b1;
                        w_next      = S_WB_REQ;
                    end else begin
                        w_next = S_RF_REQ;
                    end
                end

                S_WB_REQ: begin
                    mem_req_valid = 1'b1;
                    mem_wr        = 1'b1;
                    mem_addr      = {r_vic_tag, r_idx, 3'b000};
                    mem_wdata     = r_vic_data;
                    if (mem_req_ready) begin
                        w_next = S_WB_WAIT;
                    end
                end

                S_WB_WAIT: begin
                    if (mem_resp_valid) begin
                        w_next = S_RF_REQ;
                    end
                end

                S_RF_REQ: begin
                    mem_req_valid = 1'b1;
                    mem_addr      = {r_tag, r_idx, 3'b000};
                    if (mem_req_ready) begin
                        w_next = S_RF_WAIT;
                    end
                end

                S_RF_WAIT: begin
                    if (mem_resp_valid) begin
                        w_refill_latch = 1'b1;
                        w_next         = S_REFILL;
                    end
                end

                S_REFILL: begin
                    data_en     = 1'b1;
                    data_wr     = 1'b1;
                    data_addr   = r_idx;
                    data_wdata  = r_wr ? w_merge : r_refill;
                    data_wmask  = 8'hFF;
                    meta_en     = 1'b1;
                    meta_wr     = 1'b1;
                    meta_addr   = r_idx;
                    meta_wvalid = 1'b1;
                    meta_wdirty = r_wr;
                    meta_wtag   = r_tag;
                    resp_valid  = 1'b1;
                    resp_rdata  = r_wr ? 64'd0 : r_refill;
                    w_next      = S_IDLE;
                end

                S_FLUSH: begin
                    w_next = S_IDLE;
                end

                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22051110_cache_miss_ctrl.sv
// ============================================================================
// tb_ysyx_22051110_cache_miss_ctrl
//
// Directed bench for the cache miss controller. The bench plays the part of
// the meta/data RAMs (driving their read data directly) and of memory.
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// well away from the rising edge where the DUT updates.
// ============================================================================
module tb_ysyx_22051110_cache_miss_ctrl;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        flush_in;
    logic        meta_en;
    logic        meta_wr;
    logic        meta_flush;
    logic [5:0]  meta_addr;
    logic        meta_wvalid;
    logic        meta_wdirty;
    logic [22:0] meta_wtag;
    logic        meta_valid;
    logic        meta_dirty;
    logic [22:0] meta_tag;
    logic        data_en;
    logic        data_wr;
    logic [5:0]  data_addr;
    logic [63:0] data_wdata;
    logic [7:0]  data_wmask;
    logic [63:0] data_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] ADDR_A   = 32'h8000_0208;
    localparam logic [31:0] ADDR_VIC = 32'h8000_0408;
    localparam logic [22:0] TAG_A    = 23'h40_0001;
    localparam logic [22:0] TAG_VIC  = 23'h40_0002;
    localparam logic [63:0] LINE_A   = 64'h1122_3344_5566_7788;
    localparam logic [63:0] LINE_VIC = 64'hAAAA_AAAA_AAAA_AAAA;

    ysyx_22051110_cache_miss_ctrl #(.TAG_W(23), .IDX_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_wr         (req_wr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .flush_in       (flush_in),
        .meta_en        (meta_en),
        .meta_wr        (meta_wr),
        .meta_flush     (meta_flush),
        .meta_addr      (meta_addr),
        .meta_wvalid    (meta_wvalid),
        .meta_wdirty    (meta_wdirty),
        .meta_wtag      (meta_wtag),
        .meta_valid     (meta_valid),
        .meta_dirty     (meta_dirty),
        .meta_tag       (meta_tag),
        .data_en        (data_en),
        .data_wr        (data_wr),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_wmask     (data_wmask),
        .data_rdata     (data_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reset state, including quiet outputs while req_valid/flush_in toggle.
    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b1; req_addr = ADDR_A; flush_in = 1'b1;
        @(negedge clock); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got=%0h exp=1", req_ready); end
        n_cmp++; if (meta_en !== 1'b0) begin n_err++; $display("FAIL rst_meta_en got=%0h exp=0", meta_en); end
        n_cmp++; if (data_en !== 1'b0) begin n_err++; $display("FAIL rst_data_en got=%0h exp=0", data_en); end
        n_cmp++; if (meta_flush !== 1'b0) begin n_err++; $display("FAIL rst_meta_flush got=%0h exp=0", meta_flush); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got=%0h exp=0", resp_valid); end
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_mem_req_valid got=%0h exp=0", mem_req_valid); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
        req_valid = 1'b0; flush_in = 1'b0;
        @(negedge clock); reset = 1'b1; #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_req_ready got=%0h exp=1", req_ready); end
    endtask

    // Load miss on a clean (invalid) line, accepted on the first edge after reset.
    task automatic test_load_miss_clean();
        meta_valid = 1'b0; meta_dirty = 1'b0; meta_tag = '0; data_rdata = '0;
        req_valid = 1'b1; req_addr = ADDR_A; req_wr = 1'b0; req_wdata = '0; req_wmask = '0; #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL lm_req_ready got=%0h exp=1", req_ready); end
        n_cmp++; if ({meta_en, meta_wr, data_en, data_wr} !== 4'b1010) begin n_err++; $display("FAIL lm_ram_read_cmd got=%b exp=1010", {meta_en, meta_wr, data_en, data_wr}); end
        n_cmp++; if (meta_addr !== 6'd1) begin n_err++; $display("FAIL lm_meta_addr got=%0h exp=1", meta_addr); end
        @(negedge clock); req_valid = 1'b0; #1;
        n_cmp++; if ({req_ready, resp_valid} !== 2'b00) begin n_err++; $display("FAIL lm_lookup_ready_resp got=%b exp=00", {req_ready, resp_valid}); end
        @(negedge clock); #1;
        n_cmp++; if ({mem_req_valid, mem_wr} !== 2'b10) begin n_err++; $display("FAIL lm_rf_req got=%b exp=10", {mem_req_valid, mem_wr}); end
        n_cmp++; if (mem_addr !== ADDR_A) begin n_err++; $display("FAIL lm_rf_addr got=%0h exp=%0h", mem_addr, ADDR_A); end
        mem_req_ready = 1'b1;
        @(negedge clock); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = LINE_A; #1;
        n_cmp++; if ({mem_req_valid, resp_valid, data_en} !== 3'b000) begin n_err++; $display("FAIL lm_rf_wait_quiet got=%b exp=000", {mem_req_valid, resp_valid, data_en}); end
        @(negedge clock); mem_resp_valid = 1'b0; mem_rdata = '0; #1;
        n_cmp++; if ({data_en, data_wr, data_wmask} !== {2'b11, 8'hFF}) begin n_err++; $display("FAIL lm_refill_data_cmd got=%0h exp=3ff", {data_en, data_wr, data_wmask}); end
        n_cmp++; if (data_wdata !== LINE_A) begin n_err++; $display("FAIL lm_refill_wdata got=%0h exp=%0h", data_wdata, LINE_A); end
        n_cmp++; if (data_addr !== 6'd1) begin n_err++; $display("FAIL lm_refill_data_addr got=%0h exp=1", data_addr); end
        n_cmp++; if ({meta_en, meta_wr, meta_wvalid, meta_wdirty} !== 4'b1110) begin n_err++; $display("FAIL lm_refill_meta got=%b exp=1110", {meta_en, meta_wr, meta_wvalid, meta_wdirty}); end
        n_cmp++; if (meta_wtag !== TAG_A) begin n_err++; $display("FAIL lm_refill_tag got=%0h exp=%0h", meta_wtag, TAG_A); end
        n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== LINE_A) begin n_err++; $display("FAIL lm_resp got=%0h/%0h exp=1/%0h", resp_valid, resp_rdata, LINE_A); end
        @(negedge clock); #1;
        n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL lm_back_idle got=%b exp=01", {resp_valid, req_ready}); end
    endtask

    // Load hit: response exactly one cycle after acceptance, no memory traffic.
    task automatic test_load_hit();
        meta_valid = 1'b1; meta_dirty = 1'b0; meta_tag = TAG_A; data_rdata = LINE_A;
        req_valid = 1'b1; req_addr = ADDR_A; req_wr = 1'b0; #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL lh_req_ready got=%0h exp=1", req_ready); end
        @(negedge clock); req_valid = 1'b0; #1;
        n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== LINE_A) begin n_err++; $display("FAIL lh_resp got=%0h/%0h exp=1/%0h", resp_valid, resp_rdata, LINE_A); end
        n_cmp++; if ({mem_req_valid, data_wr, meta_wr} !== 3'b000) begin n_err++; $display("FAIL lh_no_side_effects got=%b exp=000", {mem_req_valid, data_wr, meta_wr}); end
        @(negedge clock); #1;
        n_cmp++; if ({resp_valid, req_ready, mem_req_valid} !== 3'b010) begin n_err++; $display("FAIL lh_back_idle got=%b exp=010", {resp_valid, req_ready, mem_req_valid}); end
    endtask

    // Store hit: masked data write, meta marked dirty, zero response data.
    task automatic test_store_hit();
        meta_valid = 1'b1; meta_dirty = 1'b0; meta_tag = TAG_A; data_rdata = LINE_A;
        req_valid = 1'b1; req_addr = ADDR_A; req_wr = 1'b1; req_wdata = 64'h0123_4567_89AB_CDEF; req_wmask = 8'h0F;
        @(negedge clock); req_valid = 1'b0; req_wr = 1'b0; req_wdata = '0; req_wmask = '0; #1;
        n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== 64'h0) begin n_err++; $display("FAIL sh_resp got=%0h/%0h exp=1/0", resp_valid, resp_rdata); end
        n_cmp++; if ({data_en, data_wr, data_wmask} !== {2'b11, 8'h0F}) begin n_err++; $display("FAIL sh_data_cmd got=%0h exp=30f", {data_en, data_wr, data_wmask}); end
        n_cmp++; if (data_wdata !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL sh_wdata got=%0h exp=123456789abcdef", data_wdata); end
        n_cmp++; if ({meta_wr, meta_wvalid, meta_wdirty} !== 3'b111 || meta_wtag !== TAG_A) begin n_err++; $display("FAIL sh_meta got=%b/%0h exp=111/%0h", {meta_wr, meta_wvalid, meta_wdirty}, meta_wtag, TAG_A); end
        @(negedge clock); #1;
        n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL sh_back_idle got=%b exp=01", {resp_valid, req_ready}); end
    endtask

    // Store miss with a dirty victim, write-back stalled for 5 cycles.
    task automatic test_store_miss_dirty();
        meta_valid = 1'b1; meta_dirty = 1'b1; meta_tag = TAG_VIC; data_rdata = LINE_VIC;
        req_valid = 1'b1; req_addr = ADDR_A; req_wr = 1'b1; req_wdata = 64'hFF; req_wmask = 8'h01;
        @(negedge clock); req_valid = 1'b0; req_wr = 1'b0; req_wdata = '0; req_wmask = '0; #1;
        n_cmp++; if ({resp_valid, data_wr, meta_wr} !== 3'b000) begin n_err++; $display("FAIL sm_lookup_quiet got=%b exp=000", {resp_valid, data_wr, meta_wr}); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            // RAM read data now garbage: victim must already be latched.
            meta_valid = 1'b0; meta_dirty = 1'b0; meta_tag = '0; data_rdata = '0;
            mem_resp_valid = (c == 2);
            #1;
            n_cmp++; if ({mem_req_valid, mem_wr} !== 2'b11) begin n_err++; $display("FAIL sm_wb_req_c%0d got=%b exp=11", c, {mem_req_valid, mem_wr}); end
            n_cmp++; if (mem_addr !== ADDR_VIC) begin n_err++; $display("FAIL sm_wb_addr_c%0d got=%0h exp=%0h", c, mem_addr, ADDR_VIC); end
            n_cmp++; if (mem_wdata !== LINE_VIC) begin n_err++; $display("FAIL sm_wb_wdata_c%0d got=%0h exp=%0h", c, mem_wdata, LINE_VIC); end
            if (c == 5) mem_req_ready = 1'b1;
        end
        @(negedge clock); mem_req_ready = 1'b0; mem_resp_valid = 1'b0; #1;
        n_cmp++; if ({mem_req_valid, resp_valid} !== 2'b00) begin n_err++; $display("FAIL sm_wb_wait got=%b exp=00", {mem_req_valid, resp_valid}); end
        @(negedge clock); #1;
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL sm_wb_wait_hold got=%0h exp=0", mem_req_valid); end
        mem_resp_valid = 1'b1;
        @(negedge clock); mem_resp_valid = 1'b0; #1;
        n_cmp++; if ({mem_req_valid, mem_wr} !== 2'b10 || mem_addr !== ADDR_A) begin n_err++; $display("FAIL sm_rf_req got=%b/%0h exp=10/%0h", {mem_req_valid, mem_wr}, mem_addr, ADDR_A); end
        mem_req_ready = 1'b1;
        @(negedge clock); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h0;
        @(negedge clock); mem_resp_valid = 1'b0; #1;
        n_cmp++; if ({data_wr, data_wmask} !== {1'b1, 8'hFF} || data_wdata !== 64'hFF) begin n_err++; $display("FAIL sm_refill_data got=%0h/%0h exp=1ff/ff", {data_wr, data_wmask}, data_wdata); end
        n_cmp++; if ({meta_wr, meta_wvalid, meta_wdirty} !== 3'b111 || meta_wtag !== TAG_A) begin n_err++; $display("FAIL sm_refill_meta got=%b/%0h exp=111/%0h", {meta_wr, meta_wvalid, meta_wdirty}, meta_wtag, TAG_A); end
        n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== 64'h0) begin n_err++; $display("FAIL sm_resp got=%0h/%0h exp=1/0", resp_valid, resp_rdata); end
        @(negedge clock); #1;
        n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL sm_back_idle got=%b exp=01", {resp_valid, req_ready}); end
    endtask

    // Flush and request together: flush wins, request accepted 2 cycles later.
    task automatic test_flush();
        meta_valid = 1'b1; meta_dirty = 1'b0; meta_tag = TAG_A; data_rdata = LINE_A;
        flush_in = 1'b1; req_valid = 1'b1; req_addr = ADDR_A; req_wr = 1'b0; #1;
        n_cmp++; if ({meta_flush, req_ready, meta_en} !== 3'b100) begin n_err++; $display("FAIL fl_idle got=%b exp=100", {meta_flush, req_ready, meta_en}); end
        @(negedge clock); flush_in = 1'b0; #1;
        n_cmp++; if ({meta_flush, req_ready, meta_en} !== 3'b000) begin n_err++; $display("FAIL fl_flush_state got=%b exp=000", {meta_flush, req_ready, meta_en}); end
        @(negedge clock); #1;
        n_cmp++; if ({meta_flush, req_ready, meta_en} !== 3'b011) begin n_err++; $display("FAIL fl_accept got=%b exp=011", {meta_flush, req_ready, meta_en}); end
        @(negedge clock); req_valid = 1'b0; #1;
        n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== LINE_A) begin n_err++; $display("FAIL fl_resp got=%0h/%0h exp=1/%0h", resp_valid, resp_rdata, LINE_A); end
        @(negedge clock); #1;
        n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL fl_back_idle got=%b exp=01", {resp_valid, req_ready}); end
    endtask

    // Reset in RF_WAIT aborts the miss; a late memory response is ignored.
    task automatic test_reset_mid();
        meta_valid = 1'b0; meta_dirty = 1'b0; meta_tag = '0; data_rdata = '0;
        req_valid = 1'b1; req_addr = ADDR_A; req_wr = 1'b0;
        @(negedge clock); req_valid = 1'b0;
        @(negedge clock); #1;
        n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL rm_rf_req got=%0h exp=1", mem_req_valid); end
        mem_req_ready = 1'b1;
        @(negedge clock); mem_req_ready = 1'b0; #1;
        reset = 1'b0; #1;
        n_cmp++; if ({req_ready, mem_req_valid, resp_valid, data_en, meta_en} !== 5'b10000) begin n_err++; $display("FAIL rm_in_reset got=%b exp=10000", {req_ready, mem_req_valid, resp_valid, data_en, meta_en}); end
        @(negedge clock); reset = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF; #1;
        n_cmp++; if ({resp_valid, data_wr, req_ready} !== 3'b001) begin n_err++; $display("FAIL rm_late_resp got=%b exp=001", {resp_valid, data_wr, req_ready}); end
        @(negedge clock); mem_resp_valid = 1'b0; #1;
        n_cmp++; if ({resp_valid, data_wr, meta_wr, req_ready} !== 4'b0001) begin n_err++; $display("FAIL rm_after got=%b exp=0001", {resp_valid, data_wr, meta_wr, req_ready}); end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_wr = 1'b0; req_wdata = '0; req_wmask = '0;
        flush_in = 1'b0; meta_valid = 1'b0; meta_dirty = 1'b0; meta_tag = '0; data_rdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        test_reset();
        test_load_miss_clean();
        test_load_hit();
        test_store_hit();
        test_store_miss_dirty();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
